// File: rtl/mux_nx1_pipe_if.sv
// Handshake bundle for mux_nx1_pipe: upstream beat and select, flush,
// and the registered downstream result.
interface mux_nx1_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_IN  = 4
);
  localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]      in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  sel_err;
  logic                  out_valid;
  logic                  out_ready;

  // Upstream/downstream environment side.
  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, sel_err, out_valid
  );

  // Selector side.
  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, sel_err, out_valid
  );
endinterface

// File: rtl/mux_nx1_pipe.sv
// N-input selector with a registered output entry and a 1-entry skid buffer.
// in_ready depends only on registered state (and rst), never on out_ready.
module mux_nx1_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_IN  = 4
) (
  input logic           clk,
  input logic           rst,
  mux_nx1_pipe_if.slave bus
);
  localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0] main_sel_q,  main_sel_d;
  logic             main_err_q,  main_err_d;
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q,  skid_sel_d;
  logic             skid_err_q,  skid_err_d;
  logic             skid_valid_q, skid_valid_d;

  logic [WIDTH-1:0] beat_data;
  logic             beat_err;
  logic             in_ready;
  logic             accept;
  logic             pop;

  assign in_ready = !rst && !skid_valid_q;
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign pop      = main_valid_q && bus.out_ready;

  // Select the incoming beat; unused select codes yield zero data with err set.
  always_comb begin
    beat_data = '0;
    beat_err  = 1'b1;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        beat_data = bus.in_data[k*WIDTH +: WIDTH];
        beat_err  = 1'b0;
      end
    end
  end

  // Next-state for main/skid entries: flush first, then refill main from skid
  // before taking a new beat so ordering stays strictly FIFO.
  always_comb begin
    main_data_d  = main_data_q;
    main_sel_d   = main_sel_q;
    main_err_d   = main_err_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    skid_err_d   = skid_err_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_sel_d   = skid_sel_q;
        main_err_d   = skid_err_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = beat_data;
        main_sel_d   = bus.in_sel;
        main_err_d   = beat_err;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled; park the beat in skid, which closes in_ready.
      skid_data_d  = beat_data;
      skid_sel_d   = bus.in_sel;
      skid_err_d   = beat_err;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data_q  <= '0;
      main_sel_q   <= '0;
      main_err_q   <= 1'b0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_sel_q   <= main_sel_d;
      main_err_q   <= main_err_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Outputs come straight from the main entry.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_data  = main_data_q;
    bus.out_sel   = main_sel_q;
    bus.sel_err   = main_err_q;
    bus.out_valid = main_valid_q;
  end
endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe: one N_IN=4 instance for the main flow and
// one N_IN=3 instance for out-of-range selects.
module tb_mux_nx1_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errs   = 0;

  always #5 clk = ~clk;

  mux_nx1_pipe_if #(.WIDTH(32), .N_IN(4)) bus_a ();
  mux_nx1_pipe_if #(.WIDTH(32), .N_IN(3)) bus_b ();

  mux_nx1_pipe #(.WIDTH(32), .N_IN(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mux_nx1_pipe #(.WIDTH(32), .N_IN(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic [1:0] s, input logic ordy);
    bus_a.in_valid  = v;
    bus_a.in_sel    = s;
    bus_a.out_ready = ordy;
  endtask

  task automatic check_out_a(input string tag, input logic v, input logic [31:0] d);
    check_eq({tag, "_valid"}, {31'd0, bus_a.out_valid}, {31'd0, v});
    if (v) check_eq({tag, "_data"}, bus_a.out_data, d);
  endtask

  // Skid entry valid must imply main entry valid.
  always @(negedge clk) begin
    if (!rst) begin
      skid_inv_a: assert (!dut_a.skid_valid_q || dut_a.main_valid_q)
        else $error("skid entry valid while main entry empty");
      check_eq("skid_inv", {31'd0, dut_a.skid_valid_q && !dut_a.main_valid_q}, 32'd0);
    end
  end

  initial begin
    bus_a.in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    bus_a.flush   = 1'b0;
    drive_a(1'b0, 2'd0, 1'b1);
    bus_b.in_data   = {32'hA2, 32'hA1, 32'hA0};
    bus_b.in_sel    = 2'd0;
    bus_b.in_valid  = 1'b0;
    bus_b.flush     = 1'b0;
    bus_b.out_ready = 1'b1;

    // Reset state.
    tick();
    check_eq("rst_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
    check_eq("rst_out_data", bus_a.out_data, 32'd0);
    check_eq("rst_out_sel", {30'd0, bus_a.out_sel}, 32'd0);
    check_eq("rst_sel_err_b", {31'd0, bus_b.sel_err}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", {31'd0, bus_a.in_ready}, 32'd1);

    // Pass-through: sel 2 -> 0x33 one cycle after accept.
    drive_a(1'b1, 2'd2, 1'b1);
    tick();
    check_out_a("pass", 1'b1, 32'h33);
    check_eq("pass_sel", {30'd0, bus_a.out_sel}, 32'd2);
    check_eq("pass_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
    drive_a(1'b0, 2'd0, 1'b1);
    tick();
    check_out_a("pass_drain", 1'b0, 32'h0);

    // Streaming: 8 back-to-back beats, sel cycling 0..3.
    for (int i = 0; i <= 8; i++) begin
      if (i >= 1) check_out_a("stream", 1'b1, 32'h11 * (((i - 1) % 4) + 1));
      check_eq("stream_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
      drive_a(i < 8, 2'(i % 4), 1'b1);
      tick();
    end
    check_out_a("stream_end", 1'b0, 32'h0);

    // Stall/skid: A (sel0), then B (sel1) into skid, C (sel3) waits.
    drive_a(1'b1, 2'd0, 1'b1);
    tick();
    check_out_a("stall_a", 1'b1, 32'h11);
    drive_a(1'b1, 2'd1, 1'b0);
    tick();
    check_out_a("stall_hold1", 1'b1, 32'h11);
    check_eq("stall_in_ready1", {31'd0, bus_a.in_ready}, 32'd0);
    drive_a(1'b1, 2'd3, 1'b0);
    tick();
    check_out_a("stall_hold2", 1'b1, 32'h11);
    check_eq("stall_in_ready2", {31'd0, bus_a.in_ready}, 32'd0);
    tick();
    check_out_a("stall_hold3", 1'b1, 32'h11);
    drive_a(1'b1, 2'd3, 1'b1);
    tick();
    check_out_a("stall_b", 1'b1, 32'h22);
    check_eq("stall_in_ready_open", {31'd0, bus_a.in_ready}, 32'd1);
    tick();
    check_out_a("stall_c", 1'b1, 32'h44);
    drive_a(1'b0, 2'd0, 1'b1);
    tick();
    check_out_a("stall_drain", 1'b0, 32'h0);

    // Flush with main and skid full plus an incoming beat and a pop.
    drive_a(1'b1, 2'd0, 1'b0);
    tick();
    drive_a(1'b1, 2'd1, 1'b0);
    tick();
    check_eq("flush_full", {31'd0, bus_a.in_ready}, 32'd0);
    bus_a.flush = 1'b1;
    drive_a(1'b1, 2'd2, 1'b1);
    tick();
    check_out_a("flush_out", 1'b0, 32'h0);
    check_eq("flush_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
    // Flush also drops an otherwise acceptable beat.
    drive_a(1'b1, 2'd2, 1'b1);
    tick();
    check_out_a("flush_drop", 1'b0, 32'h0);
    bus_a.flush = 1'b0;
    drive_a(1'b1, 2'd3, 1'b1);
    tick();
    check_out_a("flush_after", 1'b1, 32'h44);
    drive_a(1'b0, 2'd0, 1'b1);
    tick();
    check_out_a("flush_drain", 1'b0, 32'h0);

    // Reset mid-stall with both entries full.
    drive_a(1'b1, 2'd1, 1'b0);
    tick();
    drive_a(1'b1, 2'd2, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check_eq("rst2_in_ready_hi", {31'd0, bus_a.in_ready}, 32'd0);
    tick();
    check_eq("rst2_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
    check_eq("rst2_out_data", bus_a.out_data, 32'd0);
    check_eq("rst2_sel_err", {31'd0, bus_a.sel_err}, 32'd0);
    check_eq("rst2_out_sel", {30'd0, bus_a.out_sel}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rst2_in_ready_lo", {31'd0, bus_a.in_ready}, 32'd1);
    drive_a(1'b1, 2'd3, 1'b1);
    tick();
    check_out_a("rst2_resume", 1'b1, 32'h44);
    drive_a(1'b0, 2'd0, 1'b1);

    // Out-of-range select on N_IN=3.
    bus_b.in_valid = 1'b1;
    bus_b.in_sel   = 2'd3;
    tick();
    check_eq("oor_valid", {31'd0, bus_b.out_valid}, 32'd1);
    check_eq("oor_data", bus_b.out_data, 32'd0);
    check_eq("oor_err", {31'd0, bus_b.sel_err}, 32'd1);
    check_eq("oor_sel", {30'd0, bus_b.out_sel}, 32'd3);
    bus_b.in_sel = 2'd1;
    tick();
    check_eq("legal_data", bus_b.out_data, 32'hA1);
    check_eq("legal_err", {31'd0, bus_b.sel_err}, 32'd0);
    bus_b.in_valid = 1'b0;
    tick();
    check_eq("oor_drain", {31'd0, bus_b.out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
- Parametrised N-input selector with a registered, elastic output stage, for the datapath wherever a select feeds a pipeline boundary, e.g. forwarding and writeback selection.
- Accepts one beat per cycle on a valid/ready handshake and latches the chosen input.
- Presents the result downstream one cycle later.
- Absorbs a single downstream stall through a 1-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`.
- Supports a pipeline flush and flags out-of-range selects.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_IN, 4, number of inputs (2..16).
- SEL_W, derived as max(1, clog2(N_IN)), width of the select. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  N_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  binary select, sampled with the beat.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat this cycle.
- flush  input  1  discard all held and incoming beats.
- out_data  output  WIDTH  selected data of the head entry.
- out_sel  output  SEL_W  select value that produced out_data.
- sel_err  output  1  head entry was captured with in_sel >= N_IN.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.

Behaviour:
- Storage is two entries, each holding {data, sel, err, valid}:
  - main drives out_*.
  - skid holds an overflow beat.
- in_ready = !rst && !skid.valid. It is a function of registered state only, with no out_ready path.
- Accept: in_valid && in_ready && !flush. The captured data is in_data[in_sel] if in_sel < N_IN; otherwise it is all-zero with err=1.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1 when main is empty or draining.
- Pop: out_valid && out_ready.
- Next-state priority, highest first:
  1. rst: main.valid=0, skid.valid=0, out_data=0, out_sel=0, sel_err=0. in_ready reads 0 while rst is high and 1 in the first cycle after.
  2. flush: main.valid=0, skid.valid=0. The same-cycle input beat is dropped and a same-cycle pop is ignored. out_data, out_sel and sel_err hold their last values, which are don't-care while out_valid=0.
  3. Otherwise, by state:
     - main empty, accept: main <= beat.
     - main full, pop, skid empty, accept: main <= beat (back-to-back, full throughput).
     - main full, pop, skid empty, no accept: main.valid <= 0.
     - main full, no pop, skid empty, accept: skid <= beat. in_ready drops next cycle.
     - main full, pop, skid full: main <= skid, skid.valid <= 0. No accept is possible because in_ready=0.
     - main full, no pop: hold.
- Ordering: strict FIFO; a skid beat is never overtaken.
- Invariant: skid.valid implies main.valid. A bench assertion checks it.
- out_* are stable while out_valid && !out_ready (AXI-style hold). They change only on pop, flush or rst.
- No combinational path from in_* to out_*.
- N_IN not a power of two: unused select codes are the error case described above. They are never X.

Test Plan:
- Reset and pass-through: WIDTH=32, N_IN=4. Deassert rst with inputs 0x11,0x22,0x33,0x44; send in_sel=2 with out_ready=1 -> out_valid=1 with out_data=0x33 and out_sel=2 one cycle after accept; in_ready=1 throughout.
- Streaming: 8 consecutive beats, sel cycling 0..3, out_ready held 1 -> 8 outputs on consecutive cycles, in order, with in_ready never low.
- Stall/skid: accept beat A (sel 0), then drop out_ready for 3 cycles while offering B (sel 1) and C (sel 3) -> B lands in skid and in_ready goes 0. out_data holds A. After out_ready=1, outputs are A, B, C in order with no loss or duplication.
- Out-of-range select: N_IN=3, in_sel=3 -> out_data=0 and sel_err=1 for that beat only; the next legal beat shows sel_err=0.
- Flush with both entries full plus an incoming beat in the same cycle -> out_valid=0 and in_ready=1 next cycle; the flushed and incoming beats never appear.
- Reset mid-stall: both entries full, out_ready=0, assert rst for 1 cycle -> out_valid=0, out_data=0, sel_err=0, and accepting resumes the cycle after rst falls.
